// File: rtl/fe_capture_ctrl.sv
// fe_capture_ctrl: ULPI front-end capture sequencer feeding the sniff FIFO write port.
// Optional STAT event generation is enabled by defining FE_STAT_EVENTS_EN.
module fe_capture_ctrl #(
    parameter int unsigned pCOUNT_W = 16
) (
    input  logic                fe_clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                stop,
    input  logic [pCOUNT_W-1:0] capture_len,
    input  logic                fe_rxvalid,
    input  logic [7:0]          fe_data,
    input  logic [4:0]          fe_stat,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [17:0]         fifo_din,
    output logic                capturing,
    output logic                done,
    output logic                overflow,
    output logic [pCOUNT_W-1:0] entry_count
);

    localparam int unsigned GAP_W     = 16;
    localparam int unsigned SHORT_MAX = 7;
    // Idle count held just before the 65535th idle cycle of a gap.
    localparam logic [GAP_W-1:0] GAP_WRAP = 16'hFFFE;
    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_STAT = 2'b01;
    localparam logic [1:0] CMD_TIME = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic [4:0] stat;
        logic [2:0] gap;
    } entry_t;

    state_t              state;
    logic                s_arm;
    logic                s_stop;
    logic                s_valid;
    logic [7:0]          s_data;
    logic [4:0]          s_stat;
    entry_t              skid;
    logic                skid_valid;
    logic                first_seen;
    logic [GAP_W-1:0]    gap_cnt;

    logic                stat_ev;
    logic                ev;
    logic                start;
    logic                wr_req;
    logic                wr_counted;
    logic                skid_load;
    logic                skid_clear;
    logic                hit_limit;
    entry_t              ev_entry;
    entry_t              wr_data;
    logic [GAP_W-1:0]    gap_next;
    logic [pCOUNT_W-1:0] count_next;

    // Input sample stage: every decision acts on inputs registered one edge earlier.
    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            s_arm   <= 1'b0;
            s_stop  <= 1'b0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_stat  <= '0;
        end else begin
            s_arm   <= arm;
            s_stop  <= stop;
            s_valid <= fe_rxvalid;
            s_data  <= fe_data;
            s_stat  <= fe_stat;
        end
    end

`ifdef FE_STAT_EVENTS_EN
    logic [4:0] last_stat;

    // Last status seen by an event; a difference while idle is a STAT event.
    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            last_stat <= '0;
        end else if (start) begin
            last_stat <= '0;
        end else if ((state == S_CAPTURE) && !s_stop && ev) begin
            last_stat <= s_stat;
        end
    end

    assign stat_ev = !s_valid && (s_stat != last_stat);
`else
    assign stat_ev = 1'b0;
`endif

    // Event decode and write selection for the current sample.
    always_comb begin
        start      = (state != S_CAPTURE) && s_arm && !s_stop;
        ev         = s_valid || stat_ev;
        wr_req     = 1'b0;
        wr_counted = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        gap_next   = gap_cnt;
        wr_data    = '0;

        ev_entry.cmd  = s_valid ? CMD_DATA : CMD_STAT;
        ev_entry.data = s_valid ? s_data : 8'h00;
        ev_entry.stat = s_stat;
        ev_entry.gap  = 3'd0;

        if (ev) begin
            gap_next = '0;
            if (skid_valid) begin
                // Back-to-back after a long gap: drain the held entry, hold this one.
                wr_req     = 1'b1;
                wr_counted = 1'b1;
                wr_data    = skid;
                skid_load  = 1'b1;
            end else if (gap_cnt <= GAP_W'(SHORT_MAX)) begin
                wr_req      = 1'b1;
                wr_counted  = 1'b1;
                wr_data     = ev_entry;
                wr_data.gap = gap_cnt[2:0];
            end else begin
                wr_req    = 1'b1;
                wr_data   = entry_t'({CMD_TIME, gap_cnt});
                skid_load = 1'b1;
            end
        end else begin
            if (first_seen) begin
                gap_next = gap_cnt + GAP_W'(1);
            end
            if (skid_valid) begin
                wr_req     = 1'b1;
                wr_counted = 1'b1;
                wr_data    = skid;
                skid_clear = 1'b1;
            end else if (first_seen && (gap_cnt == GAP_WRAP)) begin
                wr_req   = 1'b1;
                wr_data  = entry_t'({CMD_TIME, 16'hFFFF});
                gap_next = '0;
            end
        end

        count_next = entry_count + pCOUNT_W'(1);
        hit_limit  = wr_counted && (capture_len != '0) && (count_next == capture_len);
    end

    // Capture state machine with registered outputs.
    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            fifo_wr     <= 1'b0;
            fifo_din    <= '0;
            capturing   <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            entry_count <= '0;
            skid        <= '0;
            skid_valid  <= 1'b0;
            first_seen  <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            fifo_wr <= 1'b0;
            case (state)
                S_CAPTURE: begin
                    if (s_stop) begin
                        state      <= S_DONE;
                        capturing  <= 1'b0;
                        done       <= 1'b1;
                        skid_valid <= 1'b0;
                    end else if (wr_req && fifo_full) begin
                        state      <= S_DONE;
                        capturing  <= 1'b0;
                        done       <= 1'b1;
                        overflow   <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        gap_cnt <= gap_next;
                        if (ev) begin
                            first_seen <= 1'b1;
                        end
                        if (wr_req) begin
                            fifo_wr  <= 1'b1;
                            fifo_din <= wr_data;
                        end
                        if (wr_counted) begin
                            entry_count <= count_next;
                        end
                        if (hit_limit) begin
                            state      <= S_DONE;
                            capturing  <= 1'b0;
                            done       <= 1'b1;
                            skid_valid <= 1'b0;
                        end else if (skid_load) begin
                            skid       <= ev_entry;
                            skid_valid <= 1'b1;
                        end else if (skid_clear) begin
                            skid_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state       <= S_CAPTURE;
                        capturing   <= 1'b1;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                        entry_count <= '0;
                        skid        <= '0;
                        skid_valid  <= 1'b0;
                        first_seen  <= 1'b0;
                        gap_cnt     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Bench for fe_capture_ctrl: random and directed traffic checked against an event-level model.
module tb_fe_capture_ctrl;

    logic        fe_clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        stop;
    logic [15:0] capture_len;
    logic        fe_rxvalid;
    logic [7:0]  fe_data;
    logic [4:0]  fe_stat;
    logic        fifo_full;
    logic        fifo_wr;
    logic [17:0] fifo_din;
    logic        capturing;
    logic        done;
    logic        overflow;
    logic [15:0] entry_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Recorded capture samples and observed FIFO writes.
    bit          rec = 1'b0;
    int          tr_cyc[$];
    logic        tr_valid[$];
    logic [7:0]  tr_data[$];
    logic [4:0]  tr_stat[$];
    logic [17:0] got_q[$];
    int          gotc_q[$];
    logic [17:0] exp_q[$];
    int          expc_q[$];
    int          exp_cnt;

    fe_capture_ctrl #(.pCOUNT_W(16)) dut (
        .fe_clk      (fe_clk),
        .reset       (reset),
        .arm         (arm),
        .stop        (stop),
        .capture_len (capture_len),
        .fe_rxvalid  (fe_rxvalid),
        .fe_data     (fe_data),
        .fe_stat     (fe_stat),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_din    (fifo_din),
        .capturing   (capturing),
        .done        (done),
        .overflow    (overflow),
        .entry_count (entry_count)
    );

    always #5 fe_clk = ~fe_clk;

    always @(posedge fe_clk) cyc <= cyc + 1;

    always @(negedge fe_clk) begin
        if (fifo_wr === 1'b1) begin
            got_q.push_back(fifo_din);
            gotc_q.push_back(cyc);
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic [4:0] s);
        fe_rxvalid = v;
        fe_data    = d;
        fe_stat    = s;
        @(posedge fe_clk);
        #1;
        if (rec) begin
            tr_cyc.push_back(cyc);
            tr_valid.push_back(v);
            tr_data.push_back(d);
            tr_stat.push_back(s);
        end
    endtask

    task automatic idle(input int n, input logic [4:0] s);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, s);
    endtask

    // Stop any running capture, then arm a fresh one; recording starts with the first captured sample.
    task automatic do_arm(input logic [4:0] s);
        rec  = 1'b0;
        stop = 1'b1;
        step(1'b0, 8'h00, s);
        stop = 1'b0;
        arm  = 1'b1;
        step(1'b0, 8'h00, s);
        arm  = 1'b0;
        tr_cyc.delete();
        tr_valid.delete();
        tr_data.delete();
        tr_stat.delete();
        got_q.delete();
        gotc_q.delete();
        rec = 1'b1;
    endtask

    function automatic int slot(input int want, input int last_wr);
        return (want > last_wr) ? want : last_wr + 1;
    endfunction

    // Event-level reference: gaps from event sample indices, TIME splits, one write per cycle in order.
    task automatic build_expected(input int limit);
        int          prev;
        int          gap;
        int          rem;
        int          nwrap;
        int          w;
        int          last_wr;
        bit          seen;
        bit          fin;
        bit          is_ev;
        logic [1:0]  cmd;
        logic [7:0]  byt;
`ifdef FE_STAT_EVENTS_EN
        logic [4:0]  last;
        last = 5'h00;
`endif
        exp_q.delete();
        expc_q.delete();
        exp_cnt = 0;
        prev    = 0;
        seen    = 1'b0;
        fin     = 1'b0;
        last_wr = -1;
        for (int i = 0; i < tr_cyc.size() && !fin; i++) begin
            is_ev = tr_valid[i];
`ifdef FE_STAT_EVENTS_EN
            if (!tr_valid[i] && tr_stat[i] != last) is_ev = 1'b1;
            if (is_ev) last = tr_stat[i];
`endif
            if (is_ev) begin
                cmd   = tr_valid[i] ? 2'b00 : 2'b01;
                byt   = tr_valid[i] ? tr_data[i] : 8'h00;
                gap   = seen ? tr_cyc[i] - prev - 1 : 0;
                nwrap = gap / 65535;
                rem   = gap % 65535;
                for (int j = 1; j <= nwrap; j++) begin
                    w = slot(prev + 65535 * j + 1, last_wr);
                    exp_q.push_back({2'b10, 16'hFFFF});
                    expc_q.push_back(w);
                    last_wr = w;
                end
                if (rem <= 7) begin
                    w = slot(tr_cyc[i] + 1, last_wr);
                    exp_q.push_back({cmd, byt, tr_stat[i], 3'(rem)});
                end else begin
                    w = slot(tr_cyc[i] + 1, last_wr);
                    exp_q.push_back({2'b10, 16'(rem)});
                    expc_q.push_back(w);
                    last_wr = w;
                    w = slot(tr_cyc[i] + 2, last_wr);
                    exp_q.push_back({cmd, byt, tr_stat[i], 3'd0});
                end
                expc_q.push_back(w);
                last_wr = w;
                exp_cnt++;
                if (limit != 0 && exp_cnt == limit) fin = 1'b1;
                prev = tr_cyc[i];
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2, 5'h00);
        total += 6;
        if (fifo_wr !== 1'b0)       begin bad++; $display("FAIL reset_fifo_wr: got %b want 0", fifo_wr); end
        if (fifo_din !== 18'h0)     begin bad++; $display("FAIL reset_fifo_din: got %h want 0", fifo_din); end
        if (capturing !== 1'b0)     begin bad++; $display("FAIL reset_capturing: got %b want 0", capturing); end
        if (done !== 1'b0)          begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (overflow !== 1'b0)      begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        if (entry_count !== 16'h0)  begin bad++; $display("FAIL reset_entry_count: got %0d want 0", entry_count); end
        reset = 1'b0;
        idle(2, 5'h00);
        total++;
        if (capturing !== 1'b0 || fifo_wr !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got cap=%b wr=%b want 0 0", capturing, fifo_wr);
        end
    endtask

    task automatic test_short_gaps();
        capture_len = 16'd0;
        do_arm(5'h01);
        step(1'b1, 8'hA5, 5'h01);
        idle(2, 5'h01);
        step(1'b1, 8'h3C, 5'h01);
        idle(7, 5'h01);
        step(1'b1, 8'h7E, 5'h01);
        idle(4, 5'h01);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL short_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (got_q.size() != 3 || got_q[1] !== {2'b00, 8'h3C, 5'h01, 3'd2}) begin
            bad++; $display("FAIL short_literal: got n=%0d want 3 entries, 2nd 0x%h", got_q.size(), {2'b00, 8'h3C, 5'h01, 3'd2});
        end
        total++;
        if (entry_count !== 16'd3 || capturing !== 1'b1) begin
            bad++; $display("FAIL short_status: got cnt=%0d cap=%b want 3 1", entry_count, capturing);
        end
    endtask

    task automatic test_long_gap();
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'h11, 5'h00);
        idle(20, 5'h00);
        step(1'b1, 8'h22, 5'h00);
        step(1'b1, 8'h33, 5'h00);
        idle(5, 5'h00);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL long_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL long_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (got_q.size() != 4 || got_q[1] !== {2'b10, 16'd20} || gotc_q[3] != gotc_q[1] + 2) begin
            bad++; $display("FAIL long_literal: got n=%0d e1=%h want 4 entries e1=%h consecutive", got_q.size(),
                            (got_q.size() > 1) ? got_q[1] : 18'h0, {2'b10, 16'd20});
        end
    endtask

    task automatic test_stat_event();
        logic [17:0] want_last;
`ifdef FE_STAT_EVENTS_EN
        want_last = {2'b00, 8'h41, 5'h05, 3'd2};
`else
        want_last = {2'b00, 8'h41, 5'h05, 3'd6};
`endif
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'h40, 5'h00);
        idle(3, 5'h00);
        step(1'b0, 8'h00, 5'h05);
        idle(2, 5'h05);
        step(1'b1, 8'h41, 5'h05);
        idle(4, 5'h05);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stat_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL stat_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== want_last) begin
            bad++; $display("FAIL stat_last_data: got n=%0d want last %h", got_q.size(), want_last);
        end
        total++;
        if (entry_count !== 16'(exp_cnt)) begin bad++; $display("FAIL stat_entry_count: got %0d want %0d", entry_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'h55, 5'h00);
        idle(70000, 5'h00);
        step(1'b1, 8'h66, 5'h00);
        idle(4, 5'h00);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL wrap_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (got_q.size() != 4 || got_q[1] !== {2'b10, 16'hFFFF} || got_q[2] !== {2'b10, 16'd4465}
            || got_q[3] !== {2'b00, 8'h66, 5'h00, 3'd0}) begin
            bad++; $display("FAIL wrap_literal: got n=%0d want TIME ffff, TIME 4465, DATA 66 t0", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [4:0] st;
        int         r;
        st = 5'h00;
        capture_len = 16'd0;
        do_arm(st);
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                step(1'b1, 8'($urandom), st);
            end else if (r < 6) begin
                st = 5'($urandom);
                step(1'b0, 8'h00, st);
            end else if (r == 6) begin
                idle(int'($urandom_range(8, 40)), st);
            end else if (r == 7) begin
                repeat (int'($urandom_range(2, 4))) step(1'b1, 8'($urandom), st);
            end else begin
                idle(int'($urandom_range(1, 7)), st);
            end
        end
        idle(10, st);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL rand_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (entry_count !== 16'(exp_cnt)) begin bad++; $display("FAIL rand_entry_count: got %0d want %0d", entry_count, exp_cnt); end
    endtask

    task automatic test_len_limit();
        capture_len = 16'd4;
        do_arm(5'h00);
        for (int b = 0; b < 10; b++) begin
            step(1'b1, 8'(8'h80 + b), 5'h00);
            idle(int'($urandom_range(0, 12)), 5'h00);
        end
        idle(5, 5'h00);
        build_expected(4);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL len_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL len_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (entry_count !== 16'd4 || done !== 1'b1 || capturing !== 1'b0) begin
            bad++; $display("FAIL len_status: got cnt=%0d done=%b cap=%b want 4 1 0", entry_count, done, capturing);
        end
        capture_len = 16'd0;
    endtask

    task automatic test_overflow();
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'h01, 5'h00);
        idle(3, 5'h00);
        fifo_full = 1'b1;
        step(1'b1, 8'h02, 5'h00);
        idle(3, 5'h00);
        step(1'b1, 8'h03, 5'h00);
        idle(3, 5'h00);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h01, 5'h00, 3'd0}) begin
            bad++; $display("FAIL ovf_writes: got n=%0d want 1 entry %h", got_q.size(), {2'b00, 8'h01, 5'h00, 3'd0});
        end
        total++;
        if (overflow !== 1'b1 || done !== 1'b1 || capturing !== 1'b0) begin
            bad++; $display("FAIL ovf_status: got ovf=%b done=%b cap=%b want 1 1 0", overflow, done, capturing);
        end
        fifo_full = 1'b0;
        do_arm(5'h00);
        idle(1, 5'h00);
        total++;
        if (overflow !== 1'b0 || done !== 1'b0 || capturing !== 1'b1) begin
            bad++; $display("FAIL ovf_rearm: got ovf=%b done=%b cap=%b want 0 0 1", overflow, done, capturing);
        end
    endtask

    task automatic test_stop();
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'hB0, 5'h00);
        idle(1, 5'h00);
        step(1'b1, 8'hB1, 5'h00);
        idle(2, 5'h00);
        rec  = 1'b0;
        stop = 1'b1;
        step(1'b1, 8'hB2, 5'h00);
        stop = 1'b0;
        step(1'b1, 8'hB3, 5'h00);
        idle(3, 5'h00);
        build_expected(0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stop_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotc_q[i] != expc_q[i]) begin
                bad++; $display("FAIL stop_entry%0d: got %h@%0d want %h@%0d", i, got_q[i], gotc_q[i], exp_q[i], expc_q[i]);
            end
        end
        total++;
        if (done !== 1'b1 || capturing !== 1'b0) begin
            bad++; $display("FAIL stop_status: got done=%b cap=%b want 1 0", done, capturing);
        end
    endtask

    task automatic test_reset_mid();
        capture_len = 16'd0;
        do_arm(5'h00);
        step(1'b1, 8'h77, 5'h00);
        idle(12, 5'h00);
        step(1'b1, 8'h78, 5'h00);
        idle(1, 5'h00);
        reset = 1'b1;
        #1;
        total++;
        if (fifo_wr !== 1'b0 || fifo_din !== 18'h0 || capturing !== 1'b0 || done !== 1'b0
            || overflow !== 1'b0 || entry_count !== 16'h0) begin
            bad++; $display("FAIL midreset_outputs: got wr=%b din=%h cap=%b done=%b ovf=%b cnt=%0d want all 0",
                            fifo_wr, fifo_din, capturing, done, overflow, entry_count);
        end
        got_q.delete();
        gotc_q.delete();
        idle(1, 5'h00);
        reset = 1'b0;
        idle(4, 5'h00);
        total++;
        if (got_q.size() != 0 || capturing !== 1'b0) begin
            bad++; $display("FAIL midreset_quiet: got writes=%0d cap=%b want 0 0", got_q.size(), capturing);
        end
        do_arm(5'h00);
        idle(5, 5'h00);
        step(1'b1, 8'h79, 5'h00);
        idle(3, 5'h00);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h79, 5'h00, 3'd0} || entry_count !== 16'd1) begin
            bad++; $display("FAIL midreset_rearm: got n=%0d cnt=%0d want 1 entry %h cnt 1",
                            got_q.size(), entry_count, {2'b00, 8'h79, 5'h00, 3'd0});
        end
    endtask

    initial begin
        reset       = 1'b1;
        arm         = 1'b0;
        stop        = 1'b0;
        capture_len = 16'd0;
        fe_rxvalid  = 1'b0;
        fe_data     = 8'h00;
        fe_stat     = 5'h00;
        fifo_full   = 1'b0;
        test_reset();
        test_short_gaps();
        test_long_gap();
        test_stat_event();
        test_wrap();
        test_random();
        test_len_limit();
        test_overflow();
        test_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
